seg_scan_capture: RTL
=====================

# seg_scan_capture

Recovers hexadecimal digit values from a time-multiplexed, active-low seven-segment display bus (per-digit anode selects plus shared segment lines) — the decode end of our segment driver path. Sits on the board-test/loopback side: samples the display lines, waits for each digit slot to settle, inverse-maps the segment pattern to a nibble, and publishes a register image of all digits with per-digit validity and a once-per-frame strobe.

## Interface
- `NUM_DIGITS`, 8: number of multiplexed digit positions; 1..8.
- `SETTLE`, 4: consecutive stable synchronized cycles required before capture; 1..255.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `an_n`  in  NUM_DIGITS  digit selects, active-low; bit i selects digit i.
- `seg_n`  in  7  segment lines, active-low; bit6=a, bit5=b, ... bit0=g.
- `digits`  out  4*NUM_DIGITS  captured nibbles; digit i in bits [4i+3:4i].
- `digit_valid`  out  NUM_DIGITS  1 = last capture of digit i matched a hex glyph.
- `code_err`  out  NUM_DIGITS  1 = last capture of digit i was non-blank and matched no glyph.
- `frame_strobe`  out  1  one-cycle pulse when every digit has been captured since the previous pulse.

## Operation
- Glyph map (active-high form, `~seg_n`): 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 77→A, 1F→b, 4E→C, 3D→d, 4F→E, 47→F. 00 = blank. Every other pattern = error.
- Input conditioning: `an_n` and `seg_n` pass through a 2-flop synchronizer; all further logic uses the synchronized copies.
- Select is valid only when exactly one `an_n` bit is low; index = position of that bit.
- FSM states: IDLE, SETTLING, HELD.
  - IDLE: select invalid; counter 0. Valid select → SETTLING, counter 1.
  - SETTLING: (an,seg) equal to previous cycle → counter+1; any change → counter restarts at 1 (still SETTLING) or → IDLE if select invalid. Counter reaching SETTLE → capture this cycle, → HELD.
  - HELD: no further captures. Any change of (an,seg) → SETTLING (counter 1) or IDLE if select invalid.
- Capture of digit i: hit → `digits[i]`=nibble, `digit_valid[i]`=1, `code_err[i]`=0. Blank → `digits[i]` unchanged, both flags 0. Miss → `digits[i]` unchanged, `digit_valid[i]`=0, `code_err[i]`=1. Any capture sets `seen[i]`.
- Frame: capture that makes `seen` all-ones → `frame_strobe`=1 on that same edge, `seen` cleared to 0 on that edge. Recapturing an already-seen digit does not re-pulse.
- Counter width = clog2(SETTLE+1); saturates in HELD, never wraps.

## Timing
- Reset (async assert, any cycle incl. mid-settle): `digits`=0, `digit_valid`=0, `code_err`=0, `frame_strobe`=0, `seen`=0, counter=0, FSM=IDLE, synchronizers=all-ones (no select). Release is synchronous to `clk`.
- Latency: inputs stable from edge k → outputs updated at edge k+2+SETTLE (2 sync + SETTLE stability cycles); `frame_strobe` high in the same cycle.
- Any input change shorter than SETTLE synchronized cycles produces no capture.
- A select/segment change in the same cycle the counter would reach SETTLE cancels the capture.
- Minimum per-digit dwell for capture: SETTLE+1 cycles. Same digit re-selected after another digit is captured again.
- All outputs registered; no combinational input-to-output path.

## Structure
- Shared package `seg7_pkg`: 16 glyph constants `SEG_0`..`SEG_F` (active-high, bit6=a), `SEG_BLANK`=7'h00, FSM state enum for IDLE/SETTLING/HELD.
- Sub-module `seg7_pattern_decode`: combinational 7-bit pattern → {nibble[3:0], hit, blank}; instantiated once on the synchronized segment bus.
- Top holds synchronizers, one-hot-low select check/encoder, stability counter, FSM, digit register file, `seen` vector.

## Test plan
- Reset then hold `an_n`=8'hFE, `seg_n`=~7'h6D for 10 cycles (SETTLE=4) → `digits[3:0]`=2, `digit_valid`=8'h01 at 6th edge after stimulus; `frame_strobe`=0.
- Scan digits 0..7 with glyphs 0..7, 8 cycles each → `digits`=32'h76543210, `digit_valid`=8'hFF, exactly one `frame_strobe` pulse, on digit 7's capture edge.
- `an_n`=8'hFB, `seg_n`=~7'h01 (invalid) → `code_err`=8'h04, `digit_valid[2]`=0, `digits[11:8]` unchanged; then ~7'h00 (blank) → both flags bit2 = 0.
- Glitch: `seg_n` toggles every 3 cycles with SETTLE=4 → no capture, outputs unchanged; `an_n`=8'hFC (two selects) held 20 cycles → no capture.
- Assert `rst` for one cycle mid-settle after 7 of 8 digits captured → all outputs 0; next full scan yields one `frame_strobe` only after all 8 digits recaptured.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment glyph constants and scan FSM state type
//
// Purpose: shared definitions for the segment scan capture path.
// Glyphs are in active-high form (bit6 = a ... bit0 = g).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_HELD     = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_scan_capture_if.sv
// rtl/seg_scan_capture_if.sv - display bus and capture result bundle
//
// Purpose: groups the multiplexed display lines and the captured register image.
// Signals:
//   an_n         digit selects, active-low (driven by the display side)
//   seg_n        segment lines, active-low, bit6 = a ... bit0 = g
//   digits       captured nibbles, digit i in [4i+3:4i]
//   digit_valid  last capture of digit i decoded to a glyph
//   code_err     last capture of digit i was non-blank and not a glyph
//   frame_strobe one-cycle pulse when every digit has been captured
// Modports: master = display/observer side, slave = capture block.
interface seg_scan_capture_if #(
  parameter int NUM_DIGITS = 8
);

  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   code_err;
  logic                    frame_strobe;

  modport master (
    output an_n,
    output seg_n,
    input  digits,
    input  digit_valid,
    input  code_err,
    input  frame_strobe
  );

  modport slave (
    input  an_n,
    input  seg_n,
    output digits,
    output digit_valid,
    output code_err,
    output frame_strobe
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - inverse seven-segment map, pattern to nibble
//
// Purpose: combinational decode of an active-high segment pattern.
// Ports:
//   pattern_i  7-bit active-high pattern (bit6 = a)
//   nibble_o   decoded hex value (0 when not a hit)
//   hit_o      pattern matched one of the 16 glyphs
//   blank_o    pattern is all segments off
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       hit_o,
  output logic       blank_o
);

  always_comb begin
    nibble_o = 4'h0;
    hit_o    = 1'b1;
    blank_o  = 1'b0;
    case (pattern_i)
      SEG_0: nibble_o = 4'h0;
      SEG_1: nibble_o = 4'h1;
      SEG_2: nibble_o = 4'h2;
      SEG_3: nibble_o = 4'h3;
      SEG_4: nibble_o = 4'h4;
      SEG_5: nibble_o = 4'h5;
      SEG_6: nibble_o = 4'h6;
      SEG_7: nibble_o = 4'h7;
      SEG_8: nibble_o = 4'h8;
      SEG_9: nibble_o = 4'h9;
      SEG_A: nibble_o = 4'hA;
      SEG_B: nibble_o = 4'hB;
      SEG_C: nibble_o = 4'hC;
      SEG_D: nibble_o = 4'hD;
      SEG_E: nibble_o = 4'hE;
      SEG_F: nibble_o = 4'hF;
      SEG_BLANK: begin
        hit_o   = 1'b0;
        blank_o = 1'b1;
      end
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - multiplexed seven-segment bus capture to register image
//
// Purpose: synchronizes the display lines, waits for each digit slot to hold
// steady for SETTLE cycles, decodes the segment pattern and stores it per digit.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  seg_scan_capture_if.slave (an_n/seg_n in, digits/flags/frame_strobe out)
module seg_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SETTLE     = 4
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_capture_if.slave bus
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W:0]   ZERO_ONE = (IDX_W + 1)'(1);

  // Synchronizers plus a one-cycle history for change detection. All reset
  // to ones so the bus looks deselected coming out of reset.
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q, an_prev_q;
  logic [6:0]            seg_s1_q, seg_s2_q, seg_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1_q    <= '1;
      an_s2_q    <= '1;
      an_prev_q  <= '1;
      seg_s1_q   <= '1;
      seg_s2_q   <= '1;
      seg_prev_q <= '1;
    end else begin
      an_s1_q    <= bus.an_n;
      an_s2_q    <= an_s1_q;
      an_prev_q  <= an_s2_q;
      seg_s1_q   <= bus.seg_n;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
    end
  end

  // Select is usable only when exactly one anode is low.
  logic [IDX_W:0]   zero_cnt;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic             changed;

  always_comb begin
    zero_cnt = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s2_q[i]) begin
        zero_cnt = zero_cnt + 1'b1;
        sel_idx  = IDX_W'(i);
      end
    end
  end

  assign sel_valid = (zero_cnt == ZERO_ONE);
  assign changed   = (an_s2_q != an_prev_q) || (seg_s2_q != seg_prev_q);

  logic [3:0] dec_nibble;
  logic       dec_hit;
  logic       dec_blank;

  seg7_pattern_decode u_decode (
    .pattern_i (~seg_s2_q),
    .nibble_o  (dec_nibble),
    .hit_o     (dec_hit),
    .blank_o   (dec_blank)
  );

  // Stability FSM. Capture fires in the cycle where the counter already
  // holds SETTLE and the lines are still unchanged, so a change landing in
  // that cycle cancels it.
  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sel_valid) begin
          state_d = ST_SETTLING;
          cnt_d   = CNT_ONE;
        end
      end
      ST_SETTLING: begin
        if (changed) begin
          if (sel_valid) begin
            cnt_d = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          capture = 1'b1;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (changed) begin
          if (sel_valid) begin
            state_d = ST_SETTLING;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Digit register image and frame tracking.
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    strobe_q, strobe_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    seen_d   = seen_q;
    strobe_d = 1'b0;
    if (capture) begin
      if (dec_hit) begin
        digits_d[{sel_idx, 2'b00} +: 4] = dec_nibble;
        valid_d[sel_idx]                = 1'b1;
        err_d[sel_idx]                  = 1'b0;
      end else if (dec_blank) begin
        valid_d[sel_idx] = 1'b0;
        err_d[sel_idx]   = 1'b0;
      end else begin
        valid_d[sel_idx] = 1'b0;
        err_d[sel_idx]   = 1'b1;
      end
      seen_d[sel_idx] = 1'b1;
      // Completing the set pulses once and starts a fresh frame.
      if (&seen_d) begin
        strobe_d = 1'b1;
        seen_d   = '0;
      end
    end
  end

  assign bus.digits       = digits_q;
  assign bus.digit_valid  = valid_q;
  assign bus.code_err     = err_q;
  assign bus.frame_strobe = strobe_q;

endmodule
